// File: rtl/lsu_ctrl.sv
// Load/store initiator between the execute stage and data memory: legality and alignment checks,
// lane steering for stores, load extraction, and an ack timeout on the memory port.
module lsu_ctrl #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;

  logic        illegal, misal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  logic        unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign req_ready   = (state_q == StIdle) && !rst;

  always_comb begin
    illegal = req_store ? (req_funct3 > 3'b010)
                        : !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal    = 1'b0;
    st_be    = 4'b1111;
    st_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misal    = req_addr[0];
        st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: misal = (req_addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    ld_b    = mem_rdata[{lane_q, 3'b000} +: 8];
    ld_h    = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = '0;
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
      3'b010:  ld_data = mem_rdata;
      3'b100:  ld_data = {24'd0, ld_b};
      3'b101:  ld_data = {16'd0, ld_h};
      default: ld_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      store_q    <= 1'b0;
      funct3_q   <= '0;
      lane_q     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            lane_q   <= req_addr[1:0];
            if (illegal || misal) begin
              // Rejected requests never touch memory; illegal funct3 outranks misalignment.
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= illegal ? 2'b10 : 2'b01;
              resp_rdata <= '0;
            end else begin
              state_q   <= StIssue;
              cnt_q     <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_addr  <= req_addr[ADDR_W+1:2];
              mem_be    <= req_store ? st_be : 4'b0000;
              mem_wdata <= req_store ? st_wdata : '0;
            end
          end
        end
        StIssue: begin
          if (mem_ack || cnt_q == TimeoutLast) begin
            // An ack in the final allowed cycle still counts as success.
            state_q    <= StResp;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b1;
            resp_err   <= mem_ack ? 2'b00 : 2'b11;
            resp_rdata <= (mem_ack && !store_q) ? ld_data : '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp: begin
          state_q    <= StIdle;
          resp_rdata <= '0;
          resp_err   <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: load extension, store lanes, rejects, timeout, reset abort,
// and back-to-back throughput.
module tb_lsu_ctrl;

  logic        clk, rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req, mem_we;
  logic [5:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  lsu_ctrl #(.ADDR_W(6), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One request; k = ack delay after mem_req rises (-1 = never). Called at a negedge.
  task automatic xact(input string tag, input bit st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input int k, input bit hold,
                      input logic [1:0] eerr, input logic [31:0] erd, input int enreq,
                      input logic [3:0] ebe, input logic [31:0] ewd, input logic [5:0] emaddr,
                      input int elat, output int acc);
    int n, t, nreq;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":ready"}, 32'(req_ready), 32'd1);
    acc = cyc;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    t = 1;
    nreq = 0;
    while (t < 40) begin
      if (mem_req) begin
        nreq++;
        check({tag, ":we"}, 32'(mem_we), 32'(st));
        check({tag, ":be"}, 32'(mem_be), 32'(ebe));
        check({tag, ":wdata"}, mem_wdata, ewd);
        check({tag, ":maddr"}, 32'(mem_addr), 32'(emaddr));
        mem_ack = (k >= 0) && (nreq == k + 1);
      end else begin
        mem_ack = 1'b0;
      end
      if (resp_valid) break;
      @(negedge clk);
      t++;
    end
    mem_ack = 1'b0;
    check({tag, ":lat"}, 32'(t), 32'(elat));
    check({tag, ":err"}, 32'(resp_err), 32'(eerr));
    check({tag, ":rdata"}, resp_rdata, erd);
    check({tag, ":nreq"}, 32'(nreq), 32'(enreq));
    @(negedge clk);
    check({tag, ":post"}, {31'd0, resp_valid} | 32'(resp_err) | resp_rdata, 32'd0);
  endtask

  int a0, a1, a2, seen;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0;
    mem_rdata = 32'h80FF7F01;
    repeat (3) @(negedge clk);
    check("rst_outs", {resp_valid, mem_req, mem_we, mem_be, resp_err, req_ready, mem_addr},
          32'd0);
    check("rst_rdata", resp_rdata | mem_wdata, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Loads against word 0x80FF7F01
    xact("lb1",  0, 3'b000, 32'h05,  0, 0, 0, 2'b00, 32'h0000007F, 1, 4'h0, 0, 6'd1, 2, a0);
    xact("lb2",  0, 3'b000, 32'h06,  0, 0, 0, 2'b00, 32'hFFFFFFFF, 1, 4'h0, 0, 6'd1, 2, a0);
    xact("lbu3", 0, 3'b100, 32'h07,  0, 0, 0, 2'b00, 32'h00000080, 1, 4'h0, 0, 6'd1, 2, a0);
    xact("lh2",  0, 3'b001, 32'h06,  0, 1, 0, 2'b00, 32'hFFFF80FF, 2, 4'h0, 0, 6'd1, 3, a0);
    xact("lhu0", 0, 3'b101, 32'h04,  0, 0, 0, 2'b00, 32'h00007F01, 1, 4'h0, 0, 6'd1, 2, a0);
    xact("lw",   0, 3'b010, 32'h104, 0, 2, 0, 2'b00, 32'h80FF7F01, 3, 4'h0, 0, 6'd1, 4, a0);

    // Stores
    xact("sh", 1, 3'b001, 32'h0E, 32'h1234ABCD, 3, 0, 2'b00, 0, 4, 4'b1100, 32'hABCDABCD,
         6'd3, 5, a0);
    xact("sb", 1, 3'b000, 32'h21, 32'h0000005A, 0, 0, 2'b00, 0, 1, 4'b0010, 32'h5A5A5A5A,
         6'd8, 2, a0);
    xact("sw", 1, 3'b010, 32'hFC, 32'hDEADBEEF, 1, 0, 2'b00, 0, 2, 4'b1111, 32'hDEADBEEF,
         6'd63, 3, a0);

    // Rejected requests
    xact("lw_mis",  0, 3'b010, 32'h02, 0, 0, 0, 2'b01, 0, 0, 4'h0, 0, 6'd0, 1, a0);
    xact("lh_mis",  0, 3'b001, 32'h03, 0, 0, 0, 2'b01, 0, 0, 4'h0, 0, 6'd0, 1, a0);
    xact("st_ill",  1, 3'b100, 32'h01, 0, 0, 0, 2'b10, 0, 0, 4'h0, 0, 6'd0, 1, a0);
    xact("ld_ill",  0, 3'b011, 32'h00, 0, 0, 0, 2'b10, 0, 0, 4'h0, 0, 6'd0, 1, a0);

    // Timeout and last-cycle ack
    xact("tmo",   0, 3'b010, 32'h08, 0, -1, 0, 2'b11, 0, 15, 4'h0, 0, 6'd2, 16, a0);
    xact("ack15", 0, 3'b010, 32'h08, 0, 14, 0, 2'b00, 32'h80FF7F01, 15, 4'h0, 0, 6'd2, 16, a0);

    // Reset during the second ISSUE cycle
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h08;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_issue", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_mreq", {30'd0, mem_req, resp_valid}, 32'd0);
    check("abort_rdy_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_rdy", 32'(req_ready), 32'd1);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid || mem_req) seen++;
    end
    check("abort_quiet", 32'(seen), 32'd0);
    xact("lw_after", 0, 3'b010, 32'h10, 0, 0, 0, 2'b00, 32'h80FF7F01, 1, 4'h0, 0, 6'd4, 2, a0);

    // Back-to-back with req_valid held
    xact("b2b0", 0, 3'b000, 32'h05, 0, 0, 1, 2'b00, 32'h0000007F, 1, 4'h0, 0, 6'd1, 2, a0);
    xact("b2b1", 0, 3'b100, 32'h07, 0, 0, 1, 2'b00, 32'h00000080, 1, 4'h0, 0, 6'd1, 2, a1);
    xact("b2b2", 0, 3'b010, 32'h00, 0, 0, 1, 2'b00, 32'h80FF7F01, 1, 4'h0, 0, 6'd0, 2, a2);
    req_valid = 1'b0;
    check("b2b_gap1", 32'(a1 - a0), 32'd3);
    check("b2b_gap2", 32'(a2 - a1), 32'd3);
    @(negedge clk);
    check("b2b_idle", {31'd0, resp_valid | mem_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store initiator that sits between the execute stage and the data memory. It accepts one load or store request per transaction from the core, checks alignment and funct3 legality, and drives the word-addressed memory port with byte enables and lane-replicated store data. It also extracts and sign/zero-extends load data from the returned word. It waits on a memory acknowledge, bounded by a timeout, and returns exactly one response per accepted request.

Parameters:
ADDR_W, 6, width of memory word index (mem_addr = addr[ADDR_W+1:2])
TIMEOUT, 15, max cycles mem_req may stay high without mem_ack before abort (1..255)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  core presents request
req_ready  out  1  block can accept request
req_store  in  1  1=store, 0=load
req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  32  byte address
req_wdata  in  32  store source (rs2)
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  32  extended load data (0 for stores/errors)
resp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
mem_req  out  1  memory request
mem_we  out  1  write enable
mem_addr  out  ADDR_W  word index
mem_be  out  4  byte enables (bit i = byte lane i)
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word, valid in mem_ack cycle
mem_ack  in  1  memory completion

Behaviour:
- States: IDLE, ISSUE, RESP. req_ready = (state==IDLE) && !rst. Accept on req_valid && req_ready; latch all req_* fields.
- Reset: state IDLE; resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata, timeout counter all 0. rst mid-ISSUE/RESP aborts: mem_req low and no resp_valid from the next cycle onward.
- Legality: loads allow funct3 000,001,010,100,101; stores allow 000,001,010; anything else -> err 10. Alignment: halfword needs addr[0]==0, word needs addr[1:0]==0, else err 01. Illegal funct3 takes precedence over misalignment.
- Error on accept: IDLE->RESP directly, no mem_req ever asserted, resp_valid next cycle with rdata=0.
- Legal accept: IDLE->ISSUE. mem_req=1 from the cycle after accept. mem_we, mem_addr, mem_be and mem_wdata are held stable until the mem_ack cycle, including the ack cycle. mem_ack may arrive in the first ISSUE cycle.
- Byte enables: SB 1<<addr[1:0]; SH 0011 (addr[1]=0) or 1100; SW 1111; loads 0000 with mem_we=0.
- mem_wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata; loads 0.
- On mem_ack in ISSUE: mem_req drops next cycle, state->RESP. For loads, capture mem_rdata in the ack cycle and select byte lane addr[1:0] or half lane addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word. For stores, rdata=0.
- Timeout: counter cleared on entering ISSUE, incremented each ISSUE cycle without ack. When counter reaches TIMEOUT with no ack in that cycle, drop mem_req and go to RESP with err 11. An ack in the same cycle the counter reaches TIMEOUT wins (treated as success).
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_err return to 0 the cycle after.
- Latency: legal access with ack k cycles after mem_req rises (k>=0) gives resp_valid at accept+2+k. Error gives accept+1. Minimum back-to-back throughput is one request per 3 cycles.
- mem_ack outside ISSUE is ignored. req_valid while req_ready=0 is ignored (the core must hold it).

Test Plan:
- Load sign-extension: mem word 0x80FF7F01, LB at addr 0x...05 (lane 1) with ack k=0 -> rdata 0x0000007F. LB at lane 2 -> 0xFFFFFFFF. LBU lane 3 -> 0x00000080. resp_valid exactly 2 cycles after accept.
- Store lanes: SH addr 0x0E, wdata 0x1234ABCD -> mem_addr=3, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1 held until ack at k=3. resp_valid at accept+5, err 00.
- Misaligned/illegal: LW addr 0x02 -> no mem_req, resp next cycle err 01, rdata 0. Store funct3=100 with addr 0x01 -> err 10.
- Timeout: LW with mem_ack never asserted, TIMEOUT=15 -> mem_req high 15 cycles then low, resp err 11. Ack arriving on the 15th ISSUE cycle -> err 00 with valid data.
- Reset mid-ISSUE: assert rst in the second ISSUE cycle -> next cycle mem_req=0, resp_valid never pulses, req_ready=1 after rst falls, and a following LW completes normally.
- Back-to-back: req_valid held high for 3 requests with k=0 -> accepts spaced 3 cycles apart, 3 responses in order, no dropped or duplicated resp_valid.
